// File: rtl/sub_bytes_serial.sv
// Forward AES SubBytes stage. It runs BYTES_PER_CYCLE S-box lookups per cycle under an En/Ry handshake.
// The result register is written only once, when every byte has been substituted.
module sub_bytes_serial #(
  parameter int BYTES_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         En,
  input  logic [127:0] PT,
  output logic         Ry,
  output logic         Busy,
  output logic [127:0] PT_2
);

  // state | meaning
  // IDLE  | waiting for En; the working register is loaded on request
  // BUSY  | substituting BYTES_PER_CYCLE bytes per edge, starting at byte 0
  // DONE  | result held on PT_2 with Ry high until En drops

  localparam int NUM_STEPS = 16 / BYTES_PER_CYCLE;
  localparam int CW        = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

  if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
      BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_param
    $error("sub_bytes_serial: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [127:0]    work_q;
  logic [127:0]    work_d;
  logic            last_step;

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [127:0] row;
    int unsigned  col;
    row = '0;
    case (a[7:4])
      4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
      4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
      4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
      4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
      4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
      4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
      4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
      4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
      4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
      4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
      4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
      4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
      4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
      4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
      4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
      4'hf: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
      default: row = '0;
    endcase
    col = 32'd15 - 32'(a[3:0]);
    return row[8*col +: 8];
  endfunction

  // Byte 0 sits in the MSBs, so byte i occupies bits [8*(15-i) +: 8].
  always_comb begin
    int idx;
    work_d = work_q;
    idx    = 0;
    for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
      idx = int'(cnt_q) * BYTES_PER_CYCLE + j;
      work_d[8*(15-idx) +: 8] = sbox(work_q[8*(15-idx) +: 8]);
    end
  end

  assign last_step = (cnt_q == CW'(NUM_STEPS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      PT_2    <= '0;
      Ry      <= 1'b0;
      Busy    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          Ry <= 1'b0;
          if (En) begin
            work_q  <= PT;
            cnt_q   <= '0;
            Busy    <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (!En) begin
            cnt_q   <= '0;
            Busy    <= 1'b0;
            Ry      <= 1'b0;
            state_q <= IDLE;
          end else if (last_step) begin
            work_q  <= work_d;
            PT_2    <= work_d;
            cnt_q   <= '0;
            Busy    <= 1'b0;
            Ry      <= 1'b1;
            state_q <= DONE;
          end else begin
            work_q  <= work_d;
            cnt_q   <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (!En) begin
            Ry      <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          cnt_q   <= '0;
          Busy    <= 1'b0;
          Ry      <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_bytes_serial.sv
// Bench for sub_bytes_serial: five instances (1..16 bytes per cycle) checked against a GF(2^8) S-box model.
// Expected results are pushed to a queue when a request is driven and popped when Ry rises.
module tb_sub_bytes_serial;

  logic         clk;
  logic         rst_n;
  logic [4:0]   en;
  logic [127:0] pt;
  wire  [4:0]   ry;
  wire  [4:0]   busy;
  wire  [127:0] pt2 [0:4];

  int n_checks;
  int n_errors;
  logic [127:0] exp_q [$];
  logic [127:0] held  [0:4];

  localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

  for (genvar k = 0; k < 5; k++) begin : g_dut
    sub_bytes_serial #(.BYTES_PER_CYCLE(1 << k)) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .En   (en[k]),
      .PT   (pt),
      .Ry   (ry[k]),
      .Busy (busy[k]),
      .PT_2 (pt2[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a ^= 8'h1b;
      b  = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] a);
    logic [7:0] inv, s;
    inv = '0;
    if (a != 8'h00)
      for (int b = 1; b < 256; b++)
        if (gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [127:0] sub_ref(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_ref(d[8*i +: 8]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request on instance k, swap PT to pt_during after capture, wait for Ry.
  task automatic run_op(input int k, input logic [127:0] data, input logic [127:0] pt_during);
    int lat;
    logic [127:0] exp;
    pt    = data;
    en[k] = 1'b1;
    exp_q.push_back(sub_ref(data));
    tick();
    pt  = pt_during;
    lat = 0;
    while (ry[k] !== 1'b1 && lat < 40) begin
      check("busy_high", 128'(busy[k]), 128'd1);
      check("pt2_hold", pt2[k], held[k]);
      tick();
      lat++;
    end
    check("latency", 128'(lat), 128'(16 >> k));
    check("ry_done", 128'(ry[k]), 128'd1);
    check("busy_done", 128'(busy[k]), 128'd0);
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check("result", pt2[k], exp);
      held[k] = exp;
    end else begin
      check("scoreboard_empty", 128'(exp_q.size()), 128'd1);
    end
  endtask

  task automatic release_en(input int k);
    en[k] = 1'b0;
    tick();
    check("ry_drop", 128'(ry[k]), 128'd0);
    check("pt2_after_drop", pt2[k], held[k]);
  endtask

  initial begin
    logic seen;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    en    = '0;
    pt    = '0;
    for (int k = 0; k < 5; k++) held[k] = '0;
    tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      check("rst_ry", 128'(ry[k]), 128'd0);
      check("rst_busy", 128'(busy[k]), 128'd0);
      check("rst_pt2", pt2[k], 128'h0);
    end
    rst_n = 1'b1;
    tick();

    // All-zero state
    run_op(0, 128'h0, 128'h0);
    check("zero_const", pt2[0], {16{8'h63}});
    release_en(0);

    // Byte ordering, PT changed mid-operation
    run_op(0, {4{32'h000153ff}}, {16{8'hff}});
    check("order_const", pt2[0], {4{32'h637ced16}});
    release_en(0);

    // FIPS-197 round-1 vector on every width
    for (int k = 0; k < 5; k++) begin
      run_op(k, FIPS_IN, FIPS_IN);
      check("fips_const", pt2[k], FIPS_OUT);
      release_en(k);
    end

    // Abort by dropping En during BUSY
    pt    = 128'h00112233445566778899aabbccddeeff;
    en[0] = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) tick();
    en[0] = 1'b0;
    tick();
    check("abort_busy", 128'(busy[0]), 128'd0);
    check("abort_ry", 128'(ry[0]), 128'd0);
    check("abort_pt2", pt2[0], FIPS_OUT);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ry[0] === 1'b1) seen = 1'b1;
    end
    check("abort_no_ry", 128'(seen), 128'd0);

    // Reset in the middle of an operation
    pt    = 128'hdeadbeef0123456789abcdeffedcba98;
    en[0] = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) tick();
    rst_n = 1'b0;
    en    = '0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) held[k] = '0;
    check("midrst_pt2", pt2[0], 128'h0);
    check("midrst_ry", 128'(ry[0]), 128'd0);
    check("midrst_busy", 128'(busy[0]), 128'd0);
    tick();
    check("midrst_idle", 128'(busy[0]), 128'd0);
    run_op(0, 128'h3243f6a8885a308d313198a2e0370734, 128'h0);

    // Hold En after Ry, then drop and immediately re-request
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_ry", 128'(ry[0]), 128'd1);
      check("hold_pt2", pt2[0], held[0]);
    end
    release_en(0);
    run_op(0, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 128'h5555aaaa5555aaaa5555aaaa5555aaaa);
    release_en(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
